div_tick_gen: RTL and testbench
===============================

DIV_TICK_GEN -- requirements
Module: div_tick_gen

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 8, giving the width of the internal divide counter and setting the maximum divisor to 2^CNT_WIDTH.
REQ-002 The block SHALL have parameter DIV_W, default 4, giving the width of the divide-select input.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_en, input, 1 bit: generator enable.
REQ-006 The block SHALL have port i_div_en, input, 1 bit: 1 = divide by 2^i_div_val; 0 = divide by 1.
REQ-007 The block SHALL have port i_div_val, input, DIV_W bits: divide exponent N.
REQ-008 The block SHALL have port i_halt, input, 1 bit: debug freeze request.
REQ-009 The block SHALL have port o_sig_out, output, 1 bit: divided square wave, 50% duty for N>=1, for consumption by a downstream rising-edge detector.
REQ-010 The block SHALL have port o_tick, output, 1 bit: one-cycle strobe marking the end of each divided period.
REQ-011 The block SHALL have port o_cfg_err, output, 1 bit: high while i_div_en=1 and i_div_val>CNT_WIDTH.

Function
REQ-012 The block SHALL implement states IDLE, RUN and HALT.
REQ-013 IDLE->RUN when i_en=1; RUN->HALT when i_halt=1 and i_en=1; HALT->RUN when i_halt=0 and i_en=1; any state->IDLE when i_en=0, with i_en=0 taking priority over i_halt.
REQ-014 Effective exponent: N = 0 if i_div_en=0; N = min(i_div_val, CNT_WIDTH) otherwise (saturating); terminal count T = 2^N - 1.
REQ-015 The counter SHALL be 0 on entry to RUN, SHALL increment by 1 each RUN cycle, and SHALL wrap to 0 in the cycle after it equals T.
REQ-016 o_tick SHALL be 1 exactly in RUN cycles where counter == T and the configuration is unchanged (REQ-019); for N=0 it is therefore 1 every RUN cycle.
REQ-017 o_sig_out SHALL be registered, SHALL equal counter bit N-1 delayed by one cycle for N>=1, and SHALL be held 0 for N=0.
REQ-018 The first o_tick SHALL occur in the 2^N-th RUN cycle after IDLE->RUN.
REQ-019 The block SHALL register {i_div_en, effective N} as a shadow configuration; when it differs from the live value in RUN, the counter SHALL clear to 0 on the next edge, o_sig_out SHALL go 0, o_tick SHALL be suppressed in that cycle, and the shadow SHALL update.
REQ-020 In HALT, the counter, o_sig_out and shadow configuration SHALL hold and o_tick SHALL be 0; on return to RUN, counting SHALL resume from the held value.
REQ-021 On entry to IDLE, the counter and o_sig_out SHALL clear to 0 and o_tick SHALL be 0.
REQ-022 If a configuration change and i_halt=1 occur in the same cycle, HALT SHALL be entered and the counter clear SHALL be applied on resumption.
REQ-023 o_cfg_err SHALL be combinational and SHALL NOT affect state.

Reset
REQ-024 While i_rst_n=0: state = IDLE, counter = 0, o_sig_out = 0, o_tick = 0, shadow configuration = {0,0}, applied asynchronously.
REQ-025 Reset asserted mid-period SHALL discard the partial count; after release, behaviour SHALL be identical to first enable.

Structure
REQ-026 The state enum type, DIV_W and the CNT_WIDTH default SHALL live in the shared timer package.
REQ-027 The shadow configuration register SHALL be an instance of param_d_ff with SET_VALUE '0 and i_en tied to 1.
REQ-028 State and counter logic SHALL be contained in the module, with no further sub-modules.

Verification
REQ-029 Directed test: i_en=1, i_div_en=1, i_div_val=2 -> o_tick every 4 cycles, first tick in the 4th RUN cycle; o_sig_out shows a 2-low/2-high pattern.
REQ-030 Directed test: i_div_en=0 -> o_tick=1 every RUN cycle and o_sig_out=0; i_div_val=12 with CNT_WIDTH=8 -> period 256 and o_cfg_err=1.
REQ-031 Directed test: i_div_val changes 3->1 when counter=5 -> counter=0 next cycle, no tick that cycle, next tick 2 cycles later.
REQ-032 Directed test: i_halt=1 for 10 cycles when counter=2 with N=3 -> outputs frozen and no tick; after release, tick 5 cycles later.
REQ-033 Directed test: i_rst_n pulsed low mid-period at counter=6 with N=4 -> all outputs 0 immediately; after release and re-enable, first tick after 16 cycles.
REQ-034 Directed test: i_en=0 and i_halt=1 in the same cycle -> IDLE, counter=0.

Source files
------------

// File: rtl/div_tick_gen_pkg.sv
// div_tick_gen shared package
// FSM state type and default widths
package div_tick_gen_pkg;

  localparam int CNT_WIDTH_DFLT = 8;
  localparam int DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/div_tick_gen_if.sv
// div_tick_gen control/status bundle
// master drives control, slave returns status
interface div_tick_gen_if #(
  parameter int DIV_W = div_tick_gen_pkg::DIV_W
);

  logic             en;
  logic             div_en;
  logic [DIV_W-1:0] div_val;
  logic             halt;
  logic             sig_out;
  logic             tick;
  logic             cfg_err;

  modport master (
    output en, div_en, div_val, halt,
    input  sig_out, tick, cfg_err
  );

  modport slave (
    input  en, div_en, div_val, halt,
    output sig_out, tick, cfg_err
  );

endinterface

// File: rtl/param_d_ff.sv
// param_d_ff: enable flop with reset value
// async active-low reset to SET_VALUE
module param_d_ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] SET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // load when enabled, otherwise hold
  always_comb begin
    q_d = q_q;
    if (i_en) q_d = i_d;
  end

  // storage register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) q_q <= SET_VALUE;
    else          q_q <= q_d;
  end

  assign o_q = q_q;

endmodule

// File: rtl/div_tick_gen.sv
// div_tick_gen: power-of-two divider
// square wave + end-of-period tick
module div_tick_gen #(
  parameter int CNT_WIDTH = div_tick_gen_pkg::CNT_WIDTH_DFLT,
  parameter int DIV_W     = div_tick_gen_pkg::DIV_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_div_en,
  input  logic [DIV_W-1:0] i_div_val,
  input  logic             i_halt,
  output logic             o_sig_out,
  output logic             o_tick,
  output logic             o_cfg_err
);

  import div_tick_gen_pkg::*;

  localparam int NW = $clog2(CNT_WIDTH + 1);
  localparam int SW = NW + 1;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   t_mask;
  logic                   sig_q, sig_d;
  logic                   sig_bit;
  logic [NW-1:0]          n_live;
  logic [SW-1:0]          live;
  logic [SW-1:0]          shd_q, shd_d;
  logic                   cfg_chg;
  logic                   at_term;
  logic                   too_big;

  assign too_big = 32'(i_div_val) > 32'(CNT_WIDTH);

  // effective exponent, saturated at CNT_WIDTH
  always_comb begin
    n_live = '0;
    if (i_div_en) begin
      if (too_big) n_live = NW'(CNT_WIDTH);
      else         n_live = NW'(i_div_val);
    end
  end

  assign live    = {i_div_en, n_live};
  assign cfg_chg = live != shd_q;

  // terminal count is a mask of N low ones
  assign t_mask  = ~({CNT_WIDTH{1'b1}} << n_live);
  assign at_term = cnt_q == t_mask;
  // bit N-1 of the counter; zero when N=0
  assign sig_bit = |(cnt_q & (t_mask ^ (t_mask >> 1)));

  // next state, counter, square wave, shadow
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    shd_d   = shd_q;
    if (!i_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sig_d   = 1'b0;
      shd_d   = live;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = '0;
          sig_d   = 1'b0;
          shd_d   = live;
        end
        RUN: begin
          if (i_halt) state_d = HALT;
          unique case (1'b1)
            cfg_chg && i_halt: begin
              // freeze; the clear lands on resume
              cnt_d = cnt_q;
            end
            cfg_chg && !i_halt: begin
              cnt_d = '0;
              sig_d = 1'b0;
              shd_d = live;
            end
            default: begin
              cnt_d = at_term ? '0
                    : cnt_q + CNT_WIDTH'(1);
              sig_d = sig_bit;
            end
          endcase
        end
        HALT: begin
          if (!i_halt) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, counter and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  param_d_ff #(
    .WIDTH     (SW),
    .SET_VALUE ('0)
  ) u_shadow (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (1'b1),
    .i_d     (shd_d),
    .o_q     (shd_q)
  );

  assign o_tick    = (state_q == RUN) && !cfg_chg && at_term;
  assign o_sig_out = sig_q;
  assign o_cfg_err = i_div_en && too_big;

endmodule

// File: tb/tb_div_tick_gen.sv
// tb_div_tick_gen: directed self-checking bench
// inputs change 1ns after posedge, checks at +2ns
module tb_div_tick_gen;

  import div_tick_gen_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic exp_b;

  div_tick_gen_if #(.DIV_W(4)) bus ();

  div_tick_gen #(
    .CNT_WIDTH (8),
    .DIV_W     (4)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (bus.en),
    .i_div_en  (bus.div_en),
    .i_div_val (bus.div_val),
    .i_halt    (bus.halt),
    .o_sig_out (bus.sig_out),
    .o_tick    (bus.tick),
    .o_cfg_err (bus.cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet(input int n, input string tag);
    int nt;
    nt = 0;
    for (int i = 0; i < n; i++) begin
      nxt();
      settle();
      if (bus.tick === 1'b1) nt++;
    end
    chk(tag, nt, 0);
  endtask

  initial begin
    int nfrz;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.div_en  = 1'b0;
    bus.div_val = '0;
    bus.halt    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_tick", bus.tick, 0);
    chk("rst_sig", bus.sig_out, 0);
    chk("rst_cfg", bus.cfg_err, 0);
    chk("rst_state", dut.state_q, IDLE);
    rst_n = 1'b1;

    // N=2: tick every 4, sig 2-low/2-high
    nxt();
    bus.en      = 1'b1;
    bus.div_en  = 1'b1;
    bus.div_val = 4'd2;
    settle();
    chk("idle_tick", bus.tick, 0);
    chk("n2_cfg", bus.cfg_err, 0);
    for (int k = 1; k <= 12; k++) begin
      nxt();
      settle();
      exp_b = (k % 4 == 0);
      chk("n2_tick", bus.tick, exp_b);
      exp_b = (k >= 2) && (((k - 2) % 4) >= 2);
      chk("n2_sig", bus.sig_out, exp_b);
    end

    // N 2->3, then 3->1 at counter=5
    nxt();
    bus.div_val = 4'd3;
    settle();
    chk("c_chg3_tick", bus.tick, 0);
    quiet(5, "c_gap3");
    nxt();
    settle();
    chk("c_cnt5", dut.cnt_q, 5);
    chk("c_sig5", bus.sig_out, 1);
    bus.div_val = 4'd1;
    settle();
    chk("c_chg1_tick", bus.tick, 0);
    nxt();
    settle();
    chk("c_clr_cnt", dut.cnt_q, 0);
    chk("c_clr_tick", bus.tick, 0);
    chk("c_clr_sig", bus.sig_out, 0);
    nxt();
    settle();
    chk("c_tick2", bus.tick, 1);

    // divide by 1
    nxt();
    bus.div_en = 1'b0;
    settle();
    chk("b_chg_tick", bus.tick, 0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      settle();
      chk("b_tick", bus.tick, 1);
      chk("b_sig", bus.sig_out, 0);
    end

    // div_val=12 saturates to 8: period 256
    nxt();
    bus.div_en  = 1'b1;
    bus.div_val = 4'd12;
    settle();
    chk("s_cfg_err", bus.cfg_err, 1);
    chk("s_chg_tick", bus.tick, 0);
    quiet(255, "s_gap1");
    nxt();
    settle();
    chk("s_tick1", bus.tick, 1);
    chk("s_sig1", bus.sig_out, 1);
    quiet(255, "s_gap2");
    nxt();
    settle();
    chk("s_tick2", bus.tick, 1);

    // halt 10 cycles at counter=2, N=3
    nxt();
    bus.div_val = 4'd3;
    settle();
    chk("h_chg_tick", bus.tick, 0);
    chk("h_cfg_err", bus.cfg_err, 0);
    nxt();
    nxt();
    nxt();
    settle();
    chk("h_cnt2", dut.cnt_q, 2);
    bus.halt = 1'b1;
    settle();
    chk("h_req_tick", bus.tick, 0);
    nfrz = 0;
    for (int k = 0; k < 9; k++) begin
      nxt();
      settle();
      if (bus.tick !== 1'b0) nfrz++;
      if (dut.cnt_q !== 8'd3) nfrz++;
      if (bus.sig_out !== 1'b0) nfrz++;
    end
    chk("h_frozen", nfrz, 0);
    nxt();
    bus.halt = 1'b0;
    settle();
    chk("h_rel_tick", bus.tick, 0);
    quiet(4, "h_gap");
    nxt();
    settle();
    chk("h_tick", bus.tick, 1);
    chk("h_sig", bus.sig_out, 1);

    // config change together with halt
    nxt();
    nxt();
    settle();
    bus.halt    = 1'b1;
    bus.div_val = 4'd2;
    settle();
    chk("g_req_tick", bus.tick, 0);
    nxt();
    bus.halt = 1'b0;
    settle();
    chk("g_hold_cnt", dut.cnt_q, 1);
    chk("g_state", dut.state_q, HALT);
    nxt();
    settle();
    chk("g_res_tick", bus.tick, 0);
    chk("g_res_state", dut.state_q, RUN);
    nxt();
    settle();
    chk("g_clr_cnt", dut.cnt_q, 0);
    quiet(2, "g_gap");
    nxt();
    settle();
    chk("g_tick", bus.tick, 1);

    // async reset mid-period, N=4 at counter=6
    nxt();
    bus.div_val = 4'd4;
    settle();
    repeat (7) nxt();
    settle();
    chk("r_cnt6", dut.cnt_q, 6);
    rst_n  = 1'b0;
    bus.en = 1'b0;
    #1;
    chk("r_cnt0", dut.cnt_q, 0);
    chk("r_tick", bus.tick, 0);
    chk("r_sig", bus.sig_out, 0);
    chk("r_state", dut.state_q, IDLE);
    nxt();
    nxt();
    rst_n  = 1'b1;
    bus.en = 1'b1;
    settle();
    chk("r_idle_tick", bus.tick, 0);
    quiet(15, "r_gap");
    nxt();
    settle();
    chk("r_tick16", bus.tick, 1);

    // disable beats halt
    nxt();
    nxt();
    nxt();
    bus.en   = 1'b0;
    bus.halt = 1'b1;
    settle();
    nxt();
    settle();
    chk("e_state", dut.state_q, IDLE);
    chk("e_cnt", dut.cnt_q, 0);
    chk("e_sig", bus.sig_out, 0);
    chk("e_tick", bus.tick, 0);

    // cfg_err boundaries
    bus.div_en  = 1'b1;
    bus.div_val = 4'd9;
    settle();
    chk("x_err9", bus.cfg_err, 1);
    bus.div_val = 4'd8;
    settle();
    chk("x_err8", bus.cfg_err, 0);
    bus.div_en  = 1'b0;
    bus.div_val = 4'd15;
    settle();
    chk("x_err_off", bus.cfg_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
